bitty_seq_ctrl: RTL and testbench

Parametrised fetch/issue sequencer for the Bitty core. It replaces the fixed four-phase run counter at the top level. It drives the instruction-memory address from an internal PC, waits a configurable memory latency, and latches the instruction. It then pulses the core start, waits for core done with a watchdog, and loads the branch-logic next PC. It adds single-step mode, a HALT opcode, a retired-instruction counter and a timeout error.

---
 rtl/bitty_seq_ctrl_if.sv | 29 ++
 rtl/bitty_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_bitty_seq_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_seq_ctrl_if.sv
// Fetch/issue bus between the Bitty sequencer, instruction memory and core.
//   mem_addr   : instruction memory address (sequencer -> memory)
//   mem_rdata  : instruction memory read data (memory -> sequencer)
//   next_pc    : branch-logic target, meaningful while core_done=1
//   instr      : latched instruction presented to the core
//   core_start : one-cycle start pulse to the core
//   core_done  : core completion pulse
// The master modport is the sequencer side; slave is the memory/core side.
interface bitty_seq_ctrl_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic [ADDR_W-1:0]  next_pc;
    logic [INSTR_W-1:0] instr;
    logic               core_start;
    logic               core_done;

    modport master (
        output mem_addr, instr, core_start,
        input  mem_rdata, next_pc, core_done
    );

    modport slave (
        input  mem_addr, instr, core_start,
        output mem_rdata, next_pc, core_done
    );
endinterface

// File: rtl/bitty_seq_ctrl.sv
// Fetch/issue sequencer for the Bitty core.
// Drives the instruction address from an internal PC, waits MEM_LAT cycles,
// latches the instruction, pulses core_start, waits for core_done under a
// watchdog and loads the branch-logic target. Supports single-step mode,
// a HALT opcode, a retired-instruction counter and a sticky timeout error.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   run          : level, free-running enable (used when step_mode=0)
//   step_mode    : 1 = one instruction per step pulse
//   step         : single-cycle pulse starting one instruction in step mode
//   bus          : fetch/issue bus (master side), see bitty_seq_ctrl_if
//   pc           : current PC
//   busy         : 1 while fetching, issuing or executing
//   halted       : sticky, set by HALT_INSTR or watchdog expiry
//   timeout_err  : sticky, set by watchdog expiry
//   retired      : completed-instruction count, wraps at 16 bits
// The interface instance must be parameterised with the same ADDR_W/INSTR_W.
module bitty_seq_ctrl #(
    parameter int                 ADDR_W     = 8,
    parameter int                 INSTR_W    = 16,
    parameter int                 MEM_LAT    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF,
    parameter int                 TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step_mode,
    input  logic                   step,
    bitty_seq_ctrl_if.master       bus,
    output logic [ADDR_W-1:0]      pc,
    output logic                   busy,
    output logic                   halted,
    output logic                   timeout_err,
    output logic [15:0]            retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] LAT_LAST  = 4'(MEM_LAT - 1);
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [3:0]           lat_q, lat_d;
    logic [7:0]           wdog_q, wdog_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 halted_q, halted_d;
    logic                 timeout_q, timeout_d;
    logic [15:0]          retired_q, retired_d;
    logic                 start_req;
    logic                 keep_running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lat_q     <= '0;
            wdog_q    <= '0;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            wdog_q    <= wdog_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        wdog_d    = wdog_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        retired_d = retired_q;
        // In step mode only the pulse starts work; run is a plain level otherwise.
        start_req    = step_mode ? step : run;
        keep_running = !step_mode && run;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = S_FETCH;
                    lat_d   = '0;
                end
            end
            S_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    instr_d = bus.mem_rdata;
                    if (bus.mem_rdata == HALT_INSTR) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            S_ISSUE: begin
                state_d = S_EXEC;
                wdog_d  = '0;
            end
            S_EXEC: begin
                // A done in the final watchdog cycle still wins over the timeout.
                if (bus.core_done) begin
                    pc_d      = bus.next_pc;
                    retired_d = retired_q + 16'd1;
                    if (keep_running) begin
                        state_d = S_FETCH;
                        lat_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wdog_q + 8'd1 == WDOG_LAST) begin
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // core_start decodes straight from the state register so an async reset
    // kills an in-flight pulse without waiting for a clock edge.
    assign bus.mem_addr   = pc_q;
    assign bus.instr      = instr_q;
    assign bus.core_start = (state_q == S_ISSUE);
    assign pc             = pc_q;
    assign busy           = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_EXEC);
    assign halted         = halted_q;
    assign timeout_err    = timeout_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_bitty_seq_ctrl.sv
`timescale 1ns/1ps
// Testbench for bitty_seq_ctrl: directed stimulus, an instruction-age model
// compared every cycle, and literal expectations at key points.
module tb_bitty_seq_ctrl;
    localparam int          MEM_LAT    = 2;
    localparam int          TIMEOUT    = 8;
    localparam logic [7:0]  RESET_PC   = 8'h00;
    localparam logic [15:0] HALT_INSTR = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  pc;
    logic        busy, halted, timeout_err;
    logic [15:0] retired;

    bitty_seq_ctrl_if #(.ADDR_W(8), .INSTR_W(16)) bus_if();

    bitty_seq_ctrl #(
        .ADDR_W(8), .INSTR_W(16), .MEM_LAT(MEM_LAT), .RESET_PC(RESET_PC),
        .HALT_INSTR(HALT_INSTR), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step_mode(step_mode), .step(step),
        .bus(bus_if), .pc(pc), .busy(busy), .halted(halted),
        .timeout_err(timeout_err), .retired(retired)
    );

    always #5 clk = ~clk;

    // ---------------- environment: memory, core, branch logic ----------------
    logic [15:0] mem [256];
    logic        done_r = 1'b0;
    logic        issue_poke = 1'b0;
    int          done_lat = 1;
    logic        br_en = 1'b0;
    logic [7:0]  br_tgt = 8'h00;

    assign bus_if.core_done = done_r | (issue_poke & bus_if.core_start);
    assign bus_if.next_pc   = br_en ? br_tgt : pc + 8'd1;

    // Memory with one register stage: data for the address seen in one cycle
    // is valid in the next, i.e. by the second cycle of a stable address.
    initial begin
        logic [7:0] a;
        bus_if.mem_rdata = '0;
        forever begin
            @(posedge clk);
            a = bus_if.mem_addr;
            #1;
            bus_if.mem_rdata = mem[a];
        end
    end

    // Core: raises done for one cycle done_lat cycles after seeing core_start.
    initial begin
        logic cs;
        int   pend;
        pend = 0;
        forever begin
            @(posedge clk);
            cs = bus_if.core_start;
            #1;
            done_r = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (cs && done_lat > 0) pend = done_lat;
                if (pend > 0) begin
                    pend = pend - 1;
                    if (pend == 0) done_r = 1'b1;
                end
            end
        end
    end

    // ---------------- model ----------------
    // One in-flight instruction is described by its age in cycles: ages
    // 0..MEM_LAT-1 fetch, MEM_LAT issues, anything later executes.
    typedef struct packed {
        logic        act;
        int          age;
        logic [7:0]  pc;
        logic [15:0] instr;
        logic        halt;
        logic        to;
        logic [15:0] ret;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r       = '0;
        r.pc    = RESET_PC;
        return r;
    endfunction

    function automatic model_t model_next(model_t s, logic run_i, logic sm_i,
                                          logic step_i, logic done_i, logic [7:0] npc_i);
        model_t n;
        n = s;
        if (s.halt) return n;
        if (!s.act) begin
            if (sm_i ? step_i : run_i) begin
                n.act = 1'b1;
                n.age = 0;
            end
        end else if (s.age < MEM_LAT - 1) begin
            n.age = s.age + 1;
        end else if (s.age == MEM_LAT - 1) begin
            n.instr = mem[s.pc];
            if (mem[s.pc] == HALT_INSTR) begin
                n.halt = 1'b1;
                n.act  = 1'b0;
            end else begin
                n.age = s.age + 1;
            end
        end else if (s.age > MEM_LAT && done_i) begin
            n.pc  = npc_i;
            n.ret = s.ret + 16'd1;
            if (!sm_i && run_i) n.age = 0;
            else                n.act = 1'b0;
        end else if (s.age == MEM_LAT + TIMEOUT - 1) begin
            // TIMEOUT cycles after the issue cycle without a done
            n.to   = 1'b1;
            n.halt = 1'b1;
            n.act  = 1'b0;
        end else begin
            n.age = s.age + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, run, step_mode, step, bus_if.core_done, bus_if.next_pc);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;
    int starts = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [15:0] prev_ret;
        prev_ret = '0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mem_addr",    32'(bus_if.mem_addr),   32'(m.pc));
                check("pc",          32'(pc),                32'(m.pc));
                check("instr",       32'(bus_if.instr),      32'(m.instr));
                check("core_start",  32'(bus_if.core_start), 32'(m.act && m.age == MEM_LAT));
                check("busy",        32'(busy),              32'(m.act));
                check("halted",      32'(halted),            32'(m.halt));
                check("timeout_err", 32'(timeout_err),       32'(m.to));
                check("retired",     32'(retired),           32'(m.ret));
                if (bus_if.core_start) starts++;
                if (retired != prev_ret)
                    $display("retire: count=%0d pc=%02h instr=%04h", retired, pc, bus_if.instr);
                prev_ret = retired;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick(1);
        step = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!bus_if.core_start && n < 60) begin
            tick(1);
            n++;
        end
        if (!bus_if.core_start) check("wait_start_bound", 32'(n), 32'(0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick(1);
            n++;
        end
        if (busy) check("wait_idle_bound", 32'(n), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_start"}, 32'(bus_if.core_start), 32'(0));
        check({tag, "_busy"},       32'(busy),              32'(0));
        check({tag, "_pc"},         32'(pc),                32'(RESET_PC));
        check({tag, "_mem_addr"},   32'(bus_if.mem_addr),   32'(RESET_PC));
        check({tag, "_instr"},      32'(bus_if.instr),      32'(0));
        check({tag, "_retired"},    32'(retired),           32'(0));
        check({tag, "_halted"},     32'(halted),            32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        mem[2] = HALT_INSTR;

        // reset values
        do_reset();
        chk_en = 1'b1;
        check_reset_outputs("reset");
        check("reset_timeout_err", 32'(timeout_err), 32'(0));

        // free run: run high in cycle 0
        starts = 0;
        run = 1'b1;
        wait_start(n);
        check("first_start_cycle", 32'(n), 32'(3));
        check("first_instr", 32'(bus_if.instr), 32'h1234);
        tick(2);
        check("pc_after_first", 32'(pc), 32'(1));
        check("retired_after_first", 32'(retired), 32'(1));
        wait_start(n);
        check("second_start_gap", 32'(n), 32'(2));

        // HALT opcode at address 2
        n = 0;
        while (!halted && n < 40) begin tick(1); n++; end
        check("halt_reached", 32'(halted), 32'(1));
        check("halt_pc", 32'(pc), 32'(2));
        check("halt_retired", 32'(retired), 32'(2));
        check("halt_instr", 32'(bus_if.instr), 32'(HALT_INSTR));
        run = 1'b0; tick(2); run = 1'b1; step_mode = 1'b1; pulse_step(); step_mode = 1'b0;
        tick(10);
        check("halt_sticky", 32'(halted), 32'(1));
        check("halt_no_third_start", 32'(starts), 32'(2));
        check("halt_busy", 32'(busy), 32'(0));
        mem[2] = 16'h1002;
        step_mode = 1'b1;
        do_reset();
        check("pc_after_reset", 32'(pc), 32'(0));
        check("halted_after_reset", 32'(halted), 32'(0));

        // single step: run=1 alone does nothing in step mode
        tick(10);
        check("step_idle_busy", 32'(busy), 32'(0));
        check("step_idle_retired", 32'(retired), 32'(0));
        starts = 0;
        pulse_step();
        wait_idle();
        check("step_one_retired", 32'(retired), 32'(1));
        check("step_one_start", 32'(starts), 32'(1));
        // step pulse during EXEC is dropped
        done_lat = 3;
        pulse_step();
        wait_start(n);
        tick(1);
        pulse_step();
        wait_idle();
        tick(5);
        check("step_exec_retired", 32'(retired), 32'(2));
        check("step_exec_starts", 32'(starts), 32'(2));
        done_lat = 1;

        // branch to F0
        br_en = 1'b1; br_tgt = 8'hF0;
        pulse_step();
        wait_idle();
        check("branch_pc", 32'(pc), 32'hF0);
        br_en = 1'b0;
        // done during ISSUE ignored; real done in the second EXEC cycle
        issue_poke = 1'b1; done_lat = 2;
        pulse_step();
        check("branch_fetch_addr", 32'(bus_if.mem_addr), 32'hF0);
        wait_start(n);
        tick(1);
        check("poke_exec1_busy", 32'(busy), 32'(1));
        check("poke_exec1_pc", 32'(pc), 32'hF0);
        tick(1);
        check("poke_exec2_busy", 32'(busy), 32'(1));
        tick(1);
        check("poke_done_busy", 32'(busy), 32'(0));
        check("poke_done_pc", 32'(pc), 32'hF1);
        check("poke_done_retired", 32'(retired), 32'(4));
        issue_poke = 1'b0; done_lat = 1;

        // pc wrap FF -> 00
        br_en = 1'b1; br_tgt = 8'hFF;
        pulse_step();
        wait_idle();
        check("wrap_pre_pc", 32'(pc), 32'hFF);
        br_en = 1'b0;
        pulse_step();
        wait_idle();
        check("wrap_pc", 32'(pc), 32'h00);
        check("wrap_retired", 32'(retired), 32'(6));

        // watchdog: core never done
        done_lat = 0;
        pulse_step();
        wait_start(n);
        tick(TIMEOUT - 1);
        check("timeout_early", 32'(timeout_err), 32'(0));
        tick(1);
        check("timeout_err", 32'(timeout_err), 32'(1));
        check("timeout_halted", 32'(halted), 32'(1));
        check("timeout_pc", 32'(pc), 32'h00);
        check("timeout_retired", 32'(retired), 32'(6));
        pulse_step();
        tick(4);
        check("timeout_sticky", 32'(timeout_err), 32'(1));

        // async reset mid-ISSUE and mid-EXEC
        done_lat = 1; step_mode = 1'b0; run = 1'b0;
        do_reset();
        run = 1'b1;
        wait_start(n);
        tick(1);
        wait_start(n);
        check("pre_reset_pc", 32'(pc), 32'(1));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_issue");
        tick(1);
        rst_n = 1'b1;
        done_lat = 3;
        wait_start(n);
        tick(1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_exec");
        run = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("final_idle", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
